// File: rtl/inv_line_receiver.sv
// Debounced receiver for an inverted (active-low) asynchronous line: synchronizer, debounce FSM, edge strobes.
// Optional rejected-transition counter enabled by defining GLITCH_COUNT_EN.
module inv_line_receiver #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       line_n,
    output logic       level,
    output logic       rise_pulse,
    output logic       fall_pulse
`ifdef GLITCH_COUNT_EN
    ,
    output logic [7:0] glitch_count
`endif
);

    typedef enum logic [1:0] {LOW, RISE_CHK, HIGH, FALL_CHK} state_e;

    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_e                 state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   s;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], line_n};
        s      = ~sync_q[SYNC_STAGES-1];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            LOW: begin
                if (s) begin
                    state_d = RISE_CHK;
                    cnt_d   = 8'd1;
                end
            end
            RISE_CHK: begin
                if (!s) begin
                    state_d = LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            HIGH: begin
                if (!s) begin
                    state_d = FALL_CHK;
                    cnt_d   = 8'd1;
                end
            end
            FALL_CHK: begin
                if (s) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = LOW;
                cnt_d   = '0;
            end
        endcase
        // Outputs are registered from the next state so they move on the accepting edge itself.
        level_d = (state_d == HIGH) || (state_d == FALL_CHK);
        rise_d  = (state_q == RISE_CHK) && (state_d == HIGH);
        fall_d  = (state_q == FALL_CHK) && (state_d == LOW);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '1;
            state_q <= LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level      = level_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

`ifdef GLITCH_COUNT_EN
    logic       reject;
    logic [7:0] glitch_q, glitch_d;

    always_comb begin
        reject   = ((state_q == RISE_CHK) && !s) || ((state_q == FALL_CHK) && s);
        glitch_d = (reject && (glitch_q != 8'hFF)) ? glitch_q + 8'd1 : glitch_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            glitch_q <= '0;
        end else begin
            glitch_q <= glitch_d;
        end
    end

    assign glitch_count = glitch_q;
`endif

endmodule

// File: doc/inv_line_receiver.md
INV_LINE_RECEIVER -- requirements
Module: inv_line_receiver

Interface
REQ-001 SHALL provide parameter SYNC_STAGES, default 2: synchronizer flop depth on line_n, legal range 2..4.
REQ-002 SHALL provide parameter DEBOUNCE_CYCLES, default 4: consecutive stable synchronized samples required to accept a level change, legal range 2..255.
REQ-003 SHALL provide port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL provide port line_n, input, 1 bit: asynchronous active-low line driven by a CMOS inverter stage; idle = 1.
REQ-006 SHALL provide port level, output, 1 bit: debounced active-high logical value of the line.
REQ-007 SHALL provide port rise_pulse, output, 1 bit: one-cycle strobe when level goes 0->1.
REQ-008 SHALL provide port fall_pulse, output, 1 bit: one-cycle strobe when level goes 1->0.
REQ-009 SHALL provide port glitch_count, output, 8 bits, present only when GLITCH_COUNT_EN is defined: number of rejected transitions.

Function
REQ-010 SHALL pass line_n through SYNC_STAGES flops; s = inverted output of the last stage.
REQ-011 SHALL implement FSM states LOW, RISE_CHK, HIGH, FALL_CHK, with an 8-bit stability counter cnt.
REQ-012 LOW: s=1 -> RISE_CHK, cnt=1; else stay.
REQ-013 RISE_CHK: s=0 -> LOW (rejected glitch); s=1 and cnt=DEBOUNCE_CYCLES-1 -> HIGH; otherwise s=1 -> cnt+1.
REQ-014 HIGH: s=0 -> FALL_CHK, cnt=1; else stay.
REQ-015 FALL_CHK: s=1 -> HIGH (rejected glitch); s=0 and cnt=DEBOUNCE_CYCLES-1 -> LOW; otherwise s=0 -> cnt+1.
REQ-016 level SHALL be registered: 1 in HIGH and FALL_CHK, 0 in LOW and RISE_CHK.
REQ-017 rise_pulse SHALL be 1 for exactly the cycle after the RISE_CHK->HIGH edge; fall_pulse likewise for FALL_CHK->LOW; the two are never 1 together.
REQ-018 Latency: level SHALL change on the (SYNC_STAGES+DEBOUNCE_CYCLES)th rising clk edge that samples the new line_n value, counting the first sampling edge as 1; 6 edges at defaults.
REQ-019 A line_n excursion lasting fewer than DEBOUNCE_CYCLES synchronized samples SHALL cause no change on level and no pulse.
REQ-020 cnt SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.

Reset
REQ-021 With rst=1 at a rising clk edge, all synchronizer flops SHALL load 1 (idle), the state SHALL load LOW, cnt SHALL load 0, level, rise_pulse and fall_pulse SHALL load 0, and glitch_count (if present) SHALL load 0.
REQ-022 rst SHALL override all other activity; an assertion during RISE_CHK or FALL_CHK SHALL abandon the check with no pulse and no glitch count.
REQ-023 After rst is released, a line_n that is already low SHALL be accepted through the normal LOW->RISE_CHK path with full REQ-018 latency.

Configuration
REQ-024 Macro GLITCH_COUNT_EN: when defined, glitch_count SHALL exist and SHALL increment on every rejected transition (REQ-013/015), saturating at 255; when undefined, the port and counter SHALL be absent and behaviour SHALL otherwise be identical.

Verification
REQ-025 Defaults; reset, then line_n 1->0 held: level=1 and rise_pulse=1 on edge 6 after the change; rise_pulse=0 on edge 7.
REQ-026 line_n low for 2 clks then high again: level stays 0, no pulses, glitch_count=1 (EN defined).
REQ-027 From HIGH, line_n 0->1 held: fall_pulse=1 for exactly one cycle and level=0 on edge 6.
REQ-028 rst asserted for 1 clk at edge 4 of a rise check: level=0, no rise_pulse; after release with line_n still 0, level=1 at 6 edges after release.
REQ-029 300 glitches of 1-clk width: glitch_count saturates at 255, level remains 0.
REQ-030 DEBOUNCE_CYCLES=2, SYNC_STAGES=3: a held low line_n gives level=1 on edge 5.
